verificador_nonce: RTL and testbench
====================================

# verificador_nonce

Receiving end of the nonce stream: takes the `nonce`/`valid` stream emitted by the nonce generator, buffers in-flight nonces until the hash core returns their results, compares each hash against a target, and latches the first winning nonce. On a hit or exhaustion of the nonce space it drives `stop` back to the generator. Sits between the generator/hash core pair and the top-level result registers.

## Interface
- `NONCE_W`, 8, nonce width
- `HASH_W`, 24, hash result width
- `DEPTH`, 4, in-flight nonce buffer depth (power of two, ≥2)
- `clk` in 1 — single clock, rising edge
- `reset_L` in 1 — reset, asynchronous and active-low
- `start` in 1 — one-cycle pulse, begins or restarts a search
- `target` in 8 — hit threshold, sampled while in SEARCH
- `nonce` in NONCE_W — nonce from generator
- `valid` in 1 — `nonce` qualifier
- `hash` in HASH_W — hash result from core
- `hash_valid` in 1 — `hash` qualifier; results return in nonce order
- `stop` out 1 — halt request to generator
- `found` out 1 — sticky, winning nonce latched
- `found_nonce` out NONCE_W — winning nonce
- `exhausted` out 1 — sticky, all-ones nonce checked with no hit
- `err` out 1 — sticky protocol error (overflow/underflow)

## Operation
- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- IDLE → SEARCH on `start`. SEARCH → FOUND on hit. SEARCH → EXHAUSTED when the popped nonce equals 2^NONCE_W−1 with no hit. FOUND/EXHAUSTED → SEARCH on `start`. `start` in SEARCH ignored.
- Entering SEARCH: buffer cleared, `found`, `exhausted`, `err` cleared, `found_nonce` held.
- Push: `valid` in SEARCH writes `nonce` into buffer. Ignored in other states.
- Pop: `hash_valid` in SEARCH pops oldest nonce and pairs it with `hash`.
- Hit: `hash[HASH_W-1 -: 8] < target` (unsigned). Hit wins over exhaustion if both apply to the same pop.
- On hit: `found_nonce` ← popped nonce, `found` ← 1, buffer flushed; later `valid`/`hash_valid` ignored.
- Overflow: push with buffer full and no simultaneous pop → nonce dropped, `err` ← 1.
- Underflow: `hash_valid` with buffer empty → ignored, `err` ← 1 (no same-cycle bypass of a push into an empty buffer).
- Simultaneous push and pop on non-empty buffer: both performed, occupancy unchanged, full buffer permitted.
- `err` does not change state; search continues.

## Timing
- Reset values: state IDLE, `stop`=1, `found`=0, `found_nonce`=0, `exhausted`=0, `err`=0, buffer empty.
- `stop` registered: 0 exactly while in SEARCH; rises the cycle after the hit/exhaustion pop edge, falls the cycle after `start`.
- `found`, `found_nonce`, `exhausted`, `err` update on the edge sampling the causing event; visible next cycle.
- Latency nonce push → eligible for pop: 1 cycle.
- Generator may emit up to 1 further `valid` after `stop` rises; it is ignored.
- `reset_L` low mid-search: all state cleared immediately, in-flight nonces lost.

## Structure
- Shared package: `NONCE_W`, `HASH_W`, `DEPTH` defaults, state encoding constants, target-slice width (8).
- Sub-module `nonce_fifo`: synchronous FIFO, DEPTH×NONCE_W, push/pop/full/empty/flush, same clock and reset.
- Top holds FSM, comparator, sticky flags, output registers.

## Test plan
- Reset, then `start`; nonces 0..3 pushed, hashes 0xFFxxxx,0xFFxxxx,0x10xxxx,… with `target`=0x20 → `found`=1, `found_nonce`=2, `stop`=1 one cycle after third pop.
- `target`=0x00, all nonces 0..255 with hashes → `exhausted`=1 after nonce 255 pops, `found`=0, `stop`=1.
- Five pushes with no pops, DEPTH=4 → `err`=1, fifth nonce dropped; subsequent pops return 0,1,2,3 in order.
- `hash_valid` with empty buffer after `start` → `err`=1, state stays SEARCH, `stop`=0.
- Simultaneous push/pop with buffer full for 10 cycles → no `err`, order preserved.
- `reset_L` low mid-search with 3 in flight, then `start` → buffer empty, first pop after restart pairs with first new nonce; `start` after FOUND clears `found`, keeps `found_nonce` until new hit.

Source files
------------

// File: rtl/verificador_nonce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : verificador_nonce_pkg
// Purpose  : Shared widths, depth default, FSM state encoding and the hit
//            comparison used by the nonce verifier.
// Revision : 1.0 - initial release
// ============================================================================
package verificador_nonce_pkg;

    localparam int unsigned c_NONCE_W  = 8;
    localparam int unsigned c_HASH_W   = 24;
    localparam int unsigned c_DEPTH    = 4;
    localparam int unsigned c_TARGET_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE      = 2'd0;
    localparam state_t c_ST_SEARCH    = 2'd1;
    localparam state_t c_ST_FOUND     = 2'd2;
    localparam state_t c_ST_EXHAUSTED = 2'd3;

    // A hash wins when its most significant byte is strictly below target.
    function automatic logic is_hit(input logic [c_TARGET_W-1:0] hash_top,
                                    input logic [c_TARGET_W-1:0] thresh);
        return hash_top < thresh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nonce_fifo
// Purpose  : Synchronous FIFO holding nonces in flight through the hash core.
// Ports    : clk, reset_L (async, active-low)
//            i_flush            - empties the FIFO (wins over push/pop)
//            i_push/i_push_data - write one entry (caller guarantees room)
//            i_pop/o_pop_data   - o_pop_data shows the oldest entry; i_pop
//                                 retires it (caller guarantees not empty)
//            o_full, o_empty    - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module nonce_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/verificador_nonce.sv
`default_nettype none
// ============================================================================
// Module   : verificador_nonce
// Purpose  : Buffers nonces from the generator until the hash core returns
//            their results (in order), compares each hash against target and
//            latches the first winner; requests stop on hit or exhaustion.
// Ports    : clk, reset_L (async, active-low), start (search pulse)
//            target            - hit threshold for hash[HASH_W-1 -: 8]
//            nonce/valid       - nonce stream from generator
//            hash/hash_valid   - results from hash core, nonce order
//            stop              - registered halt request (0 only in SEARCH)
//            found/found_nonce - sticky winner flag and winning nonce
//            exhausted         - sticky, all-ones nonce checked with no hit
//            err               - sticky overflow/underflow indication
// Revision : 1.0 - initial release
// ============================================================================
module verificador_nonce
    import verificador_nonce_pkg::*;
#(
    parameter int unsigned NONCE_W = c_NONCE_W,
    parameter int unsigned HASH_W  = c_HASH_W,
    parameter int unsigned DEPTH   = c_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  start,
    input  logic [c_TARGET_W-1:0] target,
    input  logic [NONCE_W-1:0]    nonce,
    input  logic                  valid,
    input  logic [HASH_W-1:0]     hash,
    input  logic                  hash_valid,
    output logic                  stop,
    output logic                  found,
    output logic [NONCE_W-1:0]    found_nonce,
    output logic                  exhausted,
    output logic                  err
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_stop;
    logic                 r_found;
    logic [NONCE_W-1:0]   r_found_nonce;
    logic                 r_exhausted;
    logic                 r_err;

    logic                 w_full;
    logic                 w_empty;
    logic [NONCE_W-1:0]   w_pop_nonce;

    logic                 w_in_search;
    logic                 w_start_search;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_overflow;
    logic                 w_underflow;
    logic                 w_hit;
    logic                 w_last;
    logic                 w_flush;

    assign w_in_search    = (r_state == c_ST_SEARCH);
    assign w_start_search = start && !w_in_search;

    // Pops only ever come from a non-empty buffer; a push into an empty
    // buffer is not visible to a hash arriving in the same cycle.
    assign w_pop       = w_in_search && hash_valid && !w_empty;
    // A full buffer still accepts a push when an entry leaves at the same edge.
    assign w_push      = w_in_search && valid && (!w_full || w_pop);
    assign w_overflow  = w_in_search && valid && w_full && !w_pop;
    assign w_underflow = w_in_search && hash_valid && w_empty;

    assign w_hit   = w_pop && is_hit(hash[HASH_W-1 -: c_TARGET_W], target);
    assign w_last  = w_pop && !w_hit && (w_pop_nonce == '1);
    // A hit discards everything still in flight, including a same-cycle push.
    assign w_flush = w_start_search || w_hit;

    nonce_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_L     (reset_L),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (nonce),
        .i_pop       (w_pop),
        .o_pop_data  (w_pop_nonce),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_state <= c_ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_FOUND, c_ST_EXHAUSTED: begin
                if (start) w_state_nxt = c_ST_SEARCH;
            end
            c_ST_SEARCH: begin
                if (w_hit)       w_state_nxt = c_ST_FOUND;
                else if (w_last) w_state_nxt = c_ST_EXHAUSTED;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_stop        <= 1'b1;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_exhausted   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_stop <= (w_state_nxt != c_ST_SEARCH);
            if (w_start_search) begin
                // found_nonce deliberately survives a restart.
                r_found     <= 1'b0;
                r_exhausted <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_found       <= 1'b1;
                    r_found_nonce <= w_pop_nonce;
                end
                if (w_last)                    r_exhausted <= 1'b1;
                if (w_overflow || w_underflow) r_err       <= 1'b1;
            end
        end
    end

    assign stop        = r_stop;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign exhausted   = r_exhausted;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_verificador_nonce.sv
`default_nettype none
// ============================================================================
// Module   : tb_verificador_nonce
// Purpose  : Scoreboard bench for verificador_nonce. Each driven cycle feeds a
//            queue-based behavioural model whose expected outputs are queued;
//            an independent monitor compares them one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_verificador_nonce;

    localparam int unsigned NONCE_W = 8;
    localparam int unsigned HASH_W  = 24;
    localparam int unsigned DEPTH   = 4;

    logic               clk = 1'b0;
    logic               reset_L = 1'b0;
    logic               start = 1'b0;
    logic [7:0]         target = 8'h00;
    logic [NONCE_W-1:0] nonce = '0;
    logic               valid = 1'b0;
    logic [HASH_W-1:0]  hash = '0;
    logic               hash_valid = 1'b0;
    logic               stop;
    logic               found;
    logic [NONCE_W-1:0] found_nonce;
    logic               exhausted;
    logic               err;

    verificador_nonce #(
        .NONCE_W (NONCE_W),
        .HASH_W  (HASH_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .start       (start),
        .target      (target),
        .nonce       (nonce),
        .valid       (valid),
        .hash        (hash),
        .hash_valid  (hash_valid),
        .stop        (stop),
        .found       (found),
        .found_nonce (found_nonce),
        .exhausted   (exhausted),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               stp;
        logic               fnd;
        logic [NONCE_W-1:0] fn;
        logic               exh;
        logic               er;
    } obs_t;

    obs_t  exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    string phase = "reset";
    logic [7:0] cur_tg = 8'h00;

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_SEARCH, M_FOUND, M_EXH} mode_e;
    mode_e       m_mode = M_IDLE;
    int unsigned m_buf[$];
    bit          m_found = 0, m_exh = 0, m_err = 0;
    int unsigned m_fn = 0;

    function automatic obs_t model_obs();
        obs_t o;
        o.stp = (m_mode != M_SEARCH);
        o.fnd = m_found;
        o.fn  = NONCE_W'(m_fn);
        o.exh = m_exh;
        o.er  = m_err;
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_buf.delete();
        m_found = 0; m_exh = 0; m_err = 0; m_fn = 0;
    endtask

    task automatic model_step(input bit st, input bit v, input int unsigned n,
                              input bit hv, input int unsigned h, input int unsigned tg);
        int unsigned had;
        int unsigned pn;
        bit          popped;
        if (st && m_mode != M_SEARCH) begin
            m_mode = M_SEARCH;
            m_buf.delete();
            m_found = 0; m_exh = 0; m_err = 0;
            return;
        end
        if (m_mode != M_SEARCH) return;
        had    = m_buf.size();
        popped = 0;
        pn     = 0;
        if (hv) begin
            if (had == 0) m_err = 1;
            else begin
                pn = m_buf.pop_front();
                popped = 1;
            end
        end
        if (v) begin
            if (had == DEPTH && !popped) m_err = 1;
            else m_buf.push_back(n);
        end
        if (popped) begin
            if ((h >> 16) < tg) begin
                m_found = 1;
                m_fn    = pn;
                m_buf.delete();
                m_mode  = M_FOUND;
            end else if (pn == 255) begin
                m_exh  = 1;
                m_mode = M_EXH;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input bit st, input bit v, input logic [7:0] n,
                         input bit hv, input logic [23:0] h);
        @(negedge clk);
        reset_L    = 1'b1;
        start      = st;
        valid      = v;
        nonce      = n;
        hash_valid = hv;
        hash       = h;
        target     = cur_tg;
        model_step(st, v, n, hv, h, cur_tg);
        exp_q.push_back(model_obs());
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset_L = 1'b0;
            start = 0; valid = 0; hash_valid = 0;
            model_reset();
            exp_q.push_back(model_obs());
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(0, 0, 8'h00, 0, 24'h0);
    endtask

    function automatic logic [23:0] hb(input logic [7:0] top);
        logic [15:0] lo;
        lo = 16'($urandom);
        return {top, lo};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            obs_t e;
            obs_t a;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {stop, found, found_nonce, exhausted, err};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s vec%0d: got stop=%b found=%b found_nonce=%0d exhausted=%b err=%b, need stop=%b found=%b found_nonce=%0d exhausted=%b err=%b",
                             phase, n_vec, a.stp, a.fnd, a.fn, a.exh, a.er,
                             e.stp, e.fnd, e.fn, e.exh, e.er);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset(2);
        idle(1);

        phase = "first_hit";
        cur_tg = 8'h20;
        drive(1, 0, 8'h00, 0, 24'h0);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'(i), 0, 24'h0);
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'h10));
        drive(0, 0, 8'h00, 1, hb(8'h00));
        idle(2);

        phase = "exhaust";
        cur_tg = 8'h00;
        drive(1, 0, 8'h00, 0, 24'h0);
        drive(0, 1, 8'h00, 0, 24'h0);
        for (int i = 1; i < 256; i++) drive(0, 1, 8'(i), 1, hb(8'($urandom)));
        drive(0, 0, 8'h00, 1, hb(8'h00));
        idle(2);

        phase = "overflow";
        cur_tg = 8'h10;
        drive(1, 0, 8'h00, 0, 24'h0);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'(i), 0, 24'h0);
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'h00));
        idle(2);

        phase = "underflow";
        drive(1, 0, 8'h00, 0, 24'h0);
        drive(0, 0, 8'h00, 1, hb(8'h00));
        idle(2);
        drive(1, 0, 8'h00, 0, 24'h0);
        idle(1);

        phase = "full_stream";
        do_reset(1);
        cur_tg = 8'h20;
        drive(1, 0, 8'h00, 0, 24'h0);
        for (int i = 10; i < 14; i++) drive(0, 1, 8'(i), 0, 24'h0);
        for (int i = 14; i < 24; i++) drive(0, 1, 8'(i), 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 0, 8'h00, 1, hb(8'hFF));
        drive(0, 1, 8'h99, 1, hb(8'h00));
        drive(0, 1, 8'h9A, 1, hb(8'h00));
        idle(2);

        phase = "reset_mid";
        drive(1, 0, 8'h00, 0, 24'h0);
        drive(0, 1, 8'h30, 0, 24'h0);
        drive(0, 1, 8'h31, 0, 24'h0);
        drive(0, 1, 8'h32, 0, 24'h0);
        do_reset(2);
        idle(1);
        drive(1, 0, 8'h00, 0, 24'h0);
        drive(0, 1, 8'h50, 0, 24'h0);
        drive(0, 1, 8'h51, 1, hb(8'h05));
        idle(2);
        drive(1, 0, 8'h00, 0, 24'h0);
        idle(2);

        phase = "random";
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else begin
                if ($urandom_range(0, 49) == 0) cur_tg = 8'($urandom_range(0, 16));
                drive($urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1,
                      8'($urandom), $urandom_range(0, 99) < 45, 24'($urandom));
            end
        end
        idle(3);

        phase = "drain";
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
